puf_race_controller: RTL and testbench

//  Initiator side of the delay-PUF measurement path. It latches a challenge and

---
 rtl/puf_race_controller.sv | 140 ++++++++++++++
 tb/tb_puf_race_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/puf_race_controller.sv
// Delay-PUF race initiator: latches a challenge, clears and races two edge counters EVALS times, majority-votes.
// All outputs registered from the next state; start is accepted only in IDLE and never queued.
module puf_race_controller #(
    parameter int CHAL_W       = 8,
    parameter int CLEAR_CYCLES = 4,
    parameter int TIMEOUT      = 4095,
    parameter int EVALS        = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CHAL_W-1:0] challenge,
    output logic              busy,
    output logic [CHAL_W-1:0] challenge_q,
    output logic              cnt_reset,
    output logic              cnt_enable,
    input  logic              finished_a,
    input  logic              finished_b,
    output logic              resp_valid,
    output logic              resp_bit,
    output logic              resp_tie,
    output logic              resp_timeout
);

    typedef enum logic [1:0] {IDLE, CLEAR, RACE, DONE} state_t;

    localparam logic [15:0] CLR_LAST = 16'(CLEAR_CYCLES - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [3:0]  EVALS_W  = 4'(EVALS);
    localparam logic [3:0]  HALF     = 4'(EVALS / 2);

    state_t              state_q, state_d;
    logic [15:0]         clr_q, clr_d;
    logic [15:0]         timer_q, timer_d;
    logic [3:0]          eval_q, eval_d;
    logic [3:0]          wins_q, wins_d;
    logic                tie_q, tie_d;
    logic [CHAL_W-1:0]   chal_d;
    logic                rbit_d, rtie_d, rto_d;

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        timer_d = timer_q;
        eval_d  = eval_q;
        wins_d  = wins_q;
        tie_d   = tie_q;
        chal_d  = challenge_q;
        rbit_d  = resp_bit;
        rtie_d  = resp_tie;
        rto_d   = resp_timeout;
        case (state_q)
            IDLE: begin
                if (start) begin
                    chal_d  = challenge;
                    wins_d  = '0;
                    tie_d   = 1'b0;
                    eval_d  = '0;
                    clr_d   = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_q == CLR_LAST) begin
                    timer_d = '0;
                    state_d = RACE;
                end else begin
                    clr_d = clr_q + 16'd1;
                end
            end
            RACE: begin
                // A finished pulse in the expiry cycle wins over the timeout.
                if (finished_a || finished_b) begin
                    if (finished_b && !finished_a)
                        wins_d = wins_q + 4'd1;
                    if (finished_a && finished_b)
                        tie_d = 1'b1;
                    eval_d = eval_q + 4'd1;
                    if (eval_d == EVALS_W) begin
                        rbit_d  = (wins_d > HALF);
                        rtie_d  = tie_d;
                        rto_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        clr_d   = '0;
                        state_d = CLEAR;
                    end
                end else if (timer_q == TO_LAST) begin
                    rbit_d  = 1'b0;
                    rtie_d  = tie_q;
                    rto_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            clr_q        <= '0;
            timer_q      <= '0;
            eval_q       <= '0;
            wins_q       <= '0;
            tie_q        <= 1'b0;
            busy         <= 1'b0;
            challenge_q  <= '0;
            cnt_reset    <= 1'b1;
            cnt_enable   <= 1'b0;
            resp_valid   <= 1'b0;
            resp_bit     <= 1'b0;
            resp_tie     <= 1'b0;
            resp_timeout <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_q        <= clr_d;
            timer_q      <= timer_d;
            eval_q       <= eval_d;
            wins_q       <= wins_d;
            tie_q        <= tie_d;
            busy         <= (state_d == CLEAR) || (state_d == RACE);
            challenge_q  <= chal_d;
            cnt_reset    <= (state_d != RACE);
            cnt_enable   <= (state_d == RACE);
            resp_valid   <= (state_d == DONE);
            resp_bit     <= rbit_d;
            resp_tie     <= rtie_d;
            resp_timeout <= rto_d;
        end
    end

endmodule

// File: tb/tb_puf_race_controller.sv
// Bench for puf_race_controller: one EVALS=1 and one EVALS=3 instance, planned races against a transaction-level vote model.
module tb_puf_race_controller;

    localparam int CLR = 4;
    localparam int TO  = 1000;
    localparam int EV0 = 1;
    localparam int EV1 = 3;
    localparam int K_A = 0, K_B = 1, K_T = 2, K_N = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start [2];
    logic [7:0] challenge [2];
    logic       fa [2];
    logic       fb [2];
    logic       busy [2];
    logic [7:0] challenge_q [2];
    logic       cnt_reset [2];
    logic       cnt_enable [2];
    logic       resp_valid [2];
    logic       resp_bit [2];
    logic       resp_tie [2];
    logic       resp_timeout [2];

    int nchk = 0;
    int nfail = 0;
    int rv_cnt [2];
    int exp_rv [2];
    int plan_kind [16];
    int plan_dly [16];
    int plan_n;

    always #5 clk = ~clk;

    puf_race_controller #(.CHAL_W(8), .CLEAR_CYCLES(CLR), .TIMEOUT(TO), .EVALS(EV0)) dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .challenge(challenge[0]),
        .busy(busy[0]), .challenge_q(challenge_q[0]), .cnt_reset(cnt_reset[0]),
        .cnt_enable(cnt_enable[0]), .finished_a(fa[0]), .finished_b(fb[0]),
        .resp_valid(resp_valid[0]), .resp_bit(resp_bit[0]), .resp_tie(resp_tie[0]),
        .resp_timeout(resp_timeout[0])
    );

    puf_race_controller #(.CHAL_W(8), .CLEAR_CYCLES(CLR), .TIMEOUT(TO), .EVALS(EV1)) dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .challenge(challenge[1]),
        .busy(busy[1]), .challenge_q(challenge_q[1]), .cnt_reset(cnt_reset[1]),
        .cnt_enable(cnt_enable[1]), .finished_a(fa[1]), .finished_b(fb[1]),
        .resp_valid(resp_valid[1]), .resp_bit(resp_bit[1]), .resp_tie(resp_tie[1]),
        .resp_timeout(resp_timeout[1])
    );

    always @(negedge clk) begin
        if (resp_valid[0] === 1'b1) rv_cnt[0] <= rv_cnt[0] + 1;
        if (resp_valid[1] === 1'b1) rv_cnt[1] <= rv_cnt[1] + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        nchk++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One request on instance sel following plan_kind/plan_dly; outcome predicted from the vote rules alone.
    task automatic run_req(input int sel, input logic [7:0] chal, input bit dup, input bit b2b);
        int  races, wins, n, m, ev;
        bit  eto, etie, ebit, bad;
        ev = (sel == 0) ? EV0 : EV1;
        races = 0; wins = 0; etie = 1'b0; eto = 1'b0;
        for (int i = 0; i < plan_n; i++) begin
            races++;
            if (plan_kind[i] == K_N) begin
                eto = 1'b1;
                break;
            end
            if (plan_kind[i] == K_B) wins++;
            if (plan_kind[i] == K_T) etie = 1'b1;
        end
        ebit = !eto && (wins > ev / 2);

        start[sel] = 1'b1;
        challenge[sel] = chal;
        @(negedge clk);
        start[sel] = 1'b0;
        challenge[sel] = ~chal;
        check("accept_busy", 32'(busy[sel]), 32'd1);
        check("accept_chal", 32'(challenge_q[sel]), 32'(chal));

        for (int r = 0; r < races; r++) begin
            n = 0; bad = 1'b0;
            while (cnt_enable[sel] !== 1'b1 && n < CLR + 4) begin
                if (cnt_reset[sel] !== 1'b1 || busy[sel] !== 1'b1 ||
                    resp_valid[sel] !== 1'b0 || challenge_q[sel] !== chal) bad = 1'b1;
                fa[sel] = 1'($urandom);
                fb[sel] = 1'($urandom);
                start[sel] = dup ? 1'($urandom) : 1'b0;
                @(negedge clk);
                n++;
            end
            fa[sel] = 1'b0; fb[sel] = 1'b0; start[sel] = 1'b0;
            check("clear_len", 32'(n), 32'(CLR));
            check("clear_outputs", 32'(bad), 32'd0);
            check("race_cnt_reset", 32'(cnt_reset[sel]), 32'd0);
            if (plan_kind[r] == K_N) begin
                m = 0;
                while (cnt_enable[sel] === 1'b1 && m < TO + 5) begin
                    @(negedge clk);
                    m++;
                end
                check("timeout_len", 32'(m), 32'(TO));
            end else begin
                bad = 1'b0;
                for (int c = 0; c < plan_dly[r]; c++) begin
                    @(negedge clk);
                    if (cnt_enable[sel] !== 1'b1 || challenge_q[sel] !== chal) bad = 1'b1;
                end
                check("race_hold", 32'(bad), 32'd0);
                fa[sel] = (plan_kind[r] != K_B);
                fb[sel] = (plan_kind[r] != K_A);
                @(negedge clk);
                fa[sel] = (plan_kind[r] == K_B);
                fb[sel] = (plan_kind[r] == K_A);
                check("enable_drop", 32'(cnt_enable[sel]), 32'd0);
            end
            if (r < races - 1)
                check("next_clear", 32'({busy[sel], resp_valid[sel], cnt_reset[sel]}), 32'b101);
        end

        check("done_valid", 32'(resp_valid[sel]), 32'd1);
        check("done_busy", 32'(busy[sel]), 32'd0);
        check("done_cnt", 32'({cnt_reset[sel], cnt_enable[sel]}), 32'b10);
        check("resp_bit", 32'(resp_bit[sel]), 32'(ebit));
        check("resp_tie", 32'(resp_tie[sel]), 32'(etie));
        check("resp_timeout", 32'(resp_timeout[sel]), 32'(eto));
        check("done_chal", 32'(challenge_q[sel]), 32'(chal));
        exp_rv[sel]++;
        start[sel] = dup;
        @(negedge clk);
        fa[sel] = 1'b0; fb[sel] = 1'b0; start[sel] = 1'b0;
        check("idle_after", 32'({resp_valid[sel], busy[sel]}), 32'd0);
        check("hold_fields", 32'({resp_bit[sel], resp_tie[sel], resp_timeout[sel]}),
              32'({ebit, etie, eto}));
        if (!b2b) begin
            @(negedge clk);
            check("no_queue", 32'(busy[sel]), 32'd0);
        end
    endtask

    task automatic set_plan1(input int k, input int d);
        plan_n = 1; plan_kind[0] = k; plan_dly[0] = d;
    endtask

    task automatic set_plan3(input int k0, input int k1, input int k2);
        plan_n = 3;
        plan_kind[0] = k0; plan_kind[1] = k1; plan_kind[2] = k2;
        for (int i = 0; i < 3; i++) plan_dly[i] = int'($urandom_range(0, 60));
    endtask

    initial begin
        int n;
        for (int s = 0; s < 2; s++) begin
            start[s] = 1'b0; challenge[s] = 8'h00; fa[s] = 1'b0; fb[s] = 1'b0;
            rv_cnt[s] = 0; exp_rv[s] = 0;
        end
        #3 reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("rst_ctrl", 32'({busy[s], cnt_reset[s], cnt_enable[s], resp_valid[s]}), 32'b0100);
            check("rst_resp", 32'({resp_bit[s], resp_tie[s], resp_timeout[s]}), 32'd0);
            check("rst_chal", 32'(challenge_q[s]), 32'd0);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);

        set_plan1(K_B, 37);                              run_req(0, 8'hA5, 1'b0, 1'b0);
        set_plan1(K_A, int'($urandom_range(0, 80)));     run_req(0, 8'($urandom), 1'b1, 1'b0);
        set_plan1(K_T, int'($urandom_range(0, 80)));     run_req(0, 8'($urandom), 1'b0, 1'b1);
        set_plan1(K_N, 0);                               run_req(0, 8'($urandom), 1'b0, 1'b0);
        set_plan1(K_B, TO - 1);                          run_req(0, 8'($urandom), 1'b0, 1'b0);
        set_plan1(K_A, 0);                               run_req(0, 8'($urandom), 1'b1, 1'b0);

        set_plan3(K_B, K_A, K_B);                        run_req(1, 8'($urandom), 1'b0, 1'b0);
        set_plan3(K_A, K_T, K_B);                        run_req(1, 8'($urandom), 1'b1, 1'b0);
        set_plan3(K_B, K_N, K_B);                        run_req(1, 8'($urandom), 1'b0, 1'b0);
        for (int t = 0; t < 6; t++) begin
            set_plan3(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            run_req(1, 8'($urandom), 1'($urandom), 1'($urandom));
        end

        // Reset in the middle of a race must abort without a response.
        start[0] = 1'b1; challenge[0] = 8'h3C;
        @(negedge clk);
        start[0] = 1'b0;
        n = 0;
        while (cnt_enable[0] !== 1'b1 && n < CLR + 4) begin
            @(negedge clk);
            n++;
        end
        check("rst_race_entry", 32'(cnt_enable[0]), 32'd1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid_ctrl", 32'({busy[0], cnt_reset[0], cnt_enable[0], resp_valid[0]}), 32'b0100);
        check("rst_mid_chal", 32'(challenge_q[0]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_quiet", 32'({busy[0], resp_valid[0], cnt_enable[0]}), 32'd0);

        set_plan1(int'($urandom_range(0, 2)), int'($urandom_range(0, 100)));
        run_req(0, 8'($urandom), 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("rv_count0", 32'(rv_cnt[0]), 32'(exp_rv[0]));
        check("rv_count1", 32'(rv_cnt[1]), 32'(exp_rv[1]));

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
